// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: built-in self-test initiator for the processor ALU.
// It drives alu_a/alu_b/alu_ctrl and waits SETTLE_CYCLES. It then checks alu_result
// against an internal golden model, counts mismatches and captures the first one.
// Latency: one run lasts (NUM_VECTORS [+4]) * 5 * (SETTLE_CYCLES+1) cycles from the
// accepted start edge to done.
// Backpressure: none. start is only sampled in IDLE/DONE and is ignored while busy.
// Ports:
//   clk, reset (sync, active-high), start (level)
//   busy, done, pass, fail_count[15:0], first_fail_vec[7:0], first_fail_op[3:0]
//   alu_a[31:0], alu_b[31:0], alu_ctrl[3:0] (registered stimulus), alu_result[31:0]
// Optional feature: define ALU_BIST_CORNER_EN to prepend 4 directed corner vectors.
module alu_bist_ctrl #(
  parameter int unsigned NUM_VECTORS   = 16,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] SEED_A        = 32'hAAAA_5555,
  parameter logic [31:0] SEED_B        = 32'h5555_AAAA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] fail_count,
  output logic [7:0]  first_fail_vec,
  output logic [3:0]  first_fail_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result
);

  localparam logic [3:0]  OP_AND    = 4'b0000;
  localparam logic [3:0]  OP_OR     = 4'b0001;
  localparam logic [3:0]  OP_ADD    = 4'b0010;
  localparam logic [3:0]  OP_SUB    = 4'b0110;
  localparam logic [3:0]  OP_SLT    = 4'b0111;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // An all-zero Galois LFSR state never leaves zero, so a zero seed is replaced.
  localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
  localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

`ifdef ALU_BIST_CORNER_EN
  localparam int unsigned NUM_CORNER = 4;
  localparam logic [31:0] V0_A       = 32'h0000_0000;
  localparam logic [31:0] V0_B       = 32'h0000_0000;
`else
  localparam int unsigned NUM_CORNER = 0;
  localparam logic [31:0] V0_A       = SEED_A_EFF;
  localparam logic [31:0] V0_B       = SEED_B_EFF;
`endif

  localparam int unsigned TOTAL_VECS  = NUM_VECTORS + NUM_CORNER;
  localparam logic [7:0]  LAST_VEC    = 8'(TOTAL_VECS - 1);
  localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t      state_q;
  logic        busy_q, done_q, pass_q;
  logic [15:0] fail_count_q;
  logic [7:0]  first_fail_vec_q;
  logic [3:0]  first_fail_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] lfsr_a_q, lfsr_b_q;
  logic [3:0]  cnt_q;
  logic [7:0]  vec_idx_q;
  logic [2:0]  op_idx_q;

  logic [31:0] lfsr_a_d, lfsr_b_d;
  logic [31:0] next_a_d, next_b_d;
  logic        lfsr_adv;
  logic [31:0] exp_result;
  logic        mismatch;
  logic [15:0] fail_count_d;
  logic [3:0]  next_ctrl;

  function automatic logic [31:0] galois(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
      default: return 32'h0;
    endcase
  endfunction

  // Op order within a vector: AND, OR, ADD, SUB, SLT.
  function automatic logic [3:0] op_code(input logic [2:0] idx);
    case (idx)
      3'd0:    return OP_AND;
      3'd1:    return OP_OR;
      3'd2:    return OP_ADD;
      3'd3:    return OP_SUB;
      default: return OP_SLT;
    endcase
  endfunction

`ifdef ALU_BIST_CORNER_EN
  logic [7:0] vec_next;

  function automatic logic [63:0] corner_ab(input logic [1:0] idx);
    case (idx)
      2'd0:    return {32'h0000_0000, 32'h0000_0000};
      2'd1:    return {32'hFFFF_FFFF, 32'h0000_0001};
      2'd2:    return {32'h8000_0000, 32'h7FFF_FFFF};
      default: return {32'h7FFF_FFFF, 32'hFFFF_FFFF};
    endcase
  endfunction
`endif

  always_comb begin
    lfsr_a_d     = galois(lfsr_a_q);
    lfsr_b_d     = galois(lfsr_b_q);
    exp_result   = golden(alu_a_q, alu_b_q, alu_ctrl_q);
    mismatch     = (alu_result != exp_result);
    fail_count_d = fail_count_q;
    if (mismatch && (fail_count_q != 16'hFFFF)) begin
      fail_count_d = fail_count_q + 16'd1;
    end
    next_ctrl = op_code(op_idx_q + 3'd1);
`ifdef ALU_BIST_CORNER_EN
    // Corner vectors leave the LFSRs alone; the first LFSR vector uses the seed itself.
    vec_next = vec_idx_q + 8'd1;
    if (vec_next < 8'd4) begin
      {next_a_d, next_b_d} = corner_ab(vec_next[1:0]);
      lfsr_adv             = 1'b0;
    end else if (vec_next == 8'd4) begin
      next_a_d = lfsr_a_q;
      next_b_d = lfsr_b_q;
      lfsr_adv = 1'b0;
    end else begin
      next_a_d = lfsr_a_d;
      next_b_d = lfsr_b_d;
      lfsr_adv = 1'b1;
    end
`else
    next_a_d = lfsr_a_d;
    next_b_d = lfsr_b_d;
    lfsr_adv = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_count_q     <= 16'h0;
      first_fail_vec_q <= 8'h0;
      first_fail_op_q  <= 4'h0;
      alu_a_q          <= 32'h0;
      alu_b_q          <= 32'h0;
      alu_ctrl_q       <= 4'h0;
      lfsr_a_q         <= SEED_A_EFF;
      lfsr_b_q         <= SEED_B_EFF;
      cnt_q            <= 4'h0;
      vec_idx_q        <= 8'h0;
      op_idx_q         <= 3'h0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            fail_count_q     <= 16'h0;
            first_fail_vec_q <= 8'h0;
            first_fail_op_q  <= 4'h0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            busy_q           <= 1'b1;
            lfsr_a_q         <= SEED_A_EFF;
            lfsr_b_q         <= SEED_B_EFF;
            alu_a_q          <= V0_A;
            alu_b_q          <= V0_B;
            alu_ctrl_q       <= OP_AND;
            vec_idx_q        <= 8'h0;
            op_idx_q         <= 3'h0;
            cnt_q            <= SETTLE_INIT;
            state_q          <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter starts at SETTLE_CYCLES, so WAIT lasts exactly that many cycles.
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          fail_count_q <= fail_count_d;
          // fail_count only ever grows within a run, so zero marks "no failure yet".
          if (mismatch && (fail_count_q == 16'h0)) begin
            first_fail_vec_q <= vec_idx_q;
            first_fail_op_q  <= alu_ctrl_q;
          end
          if (op_idx_q == 3'd4) begin
            if (vec_idx_q == LAST_VEC) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_count_d == 16'h0);
              state_q <= S_DONE;
            end else begin
              vec_idx_q  <= vec_idx_q + 8'd1;
              op_idx_q   <= 3'h0;
              alu_a_q    <= next_a_d;
              alu_b_q    <= next_b_d;
              alu_ctrl_q <= OP_AND;
              if (lfsr_adv) begin
                lfsr_a_q <= lfsr_a_d;
                lfsr_b_q <= lfsr_b_d;
              end
              cnt_q   <= SETTLE_INIT;
              state_q <= S_WAIT;
            end
          end else begin
            op_idx_q   <= op_idx_q + 3'd1;
            alu_ctrl_q <= next_ctrl;
            cnt_q      <= SETTLE_INIT;
            state_q    <= S_WAIT;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_count     = fail_count_q;
  assign first_fail_vec = first_fail_vec_q;
  assign first_fail_op  = first_fail_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign alu_ctrl       = alu_ctrl_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: two instances (SETTLE=1 with an injectable ADD fault,
// SETTLE=3 behind a selectable result delay line), scoreboarded against
// hand-computed stimulus and end-of-run results.
module tb_alu_bist_ctrl;

`ifdef ALU_BIST_CORNER_EN
  localparam int NCORN = 4;
  localparam logic [31:0] V0A = 32'h0000_0000, V0B = 32'h0000_0000;
  localparam logic [31:0] V1A = 32'hFFFF_FFFF, V1B = 32'h0000_0001;
`else
  localparam int NCORN = 0;
  localparam logic [31:0] V0A = 32'hAAAA_5555, V0B = 32'h5555_AAAA;
  // One Galois step of each seed: AAAA5555 -> 55552AAA ^ 80200003, 5555AAAA -> 2AAAD555.
  localparam logic [31:0] V1A = 32'hD575_2AA9, V1B = 32'h2AAA_D555;
`endif
  localparam int NV   = 4;
  localparam int NV3  = 2;
  localparam int LEN1 = (NV + NCORN) * 5 * 2;
  localparam int LEN3 = (NV3 + NCORN) * 5 * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start3;
  logic        busy, done, pass, busy3, done3, pass3;
  logic [15:0] fail_count, fail_count3;
  logic [7:0]  ffv, ffv3;
  logic [3:0]  ffo, ffo3;
  logic [31:0] alu_a, alu_b, alu_result, alu_a3, alu_b3, alu_result3;
  logic [3:0]  alu_ctrl, alu_ctrl3;
  logic        add_fault;
  int          dly;
  logic [31:0] dl [4];

  alu_bist_ctrl #(.NUM_VECTORS(NV), .SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vec(ffv), .first_fail_op(ffo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result));

  alu_bist_ctrl #(.NUM_VECTORS(NV3), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .busy(busy3), .done(done3), .pass(pass3),
    .fail_count(fail_count3), .first_fail_vec(ffv3), .first_fail_op(ffo3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_ctrl3), .alu_result(alu_result3));

  // Stand-in processor ALU.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    r = 32'h0;
    if (c == 4'b0000) r = a & b;
    else if (c == 4'b0001) r = a | b;
    else if (c == 4'b0010) r = a + b;
    else if (c == 4'b0110) r = a + ~b + 32'd1;
    else if (c == 4'b0111) r = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
    return r;
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_ctrl) ^
                      ((add_fault && alu_ctrl == 4'b0010) ? 32'h1 : 32'h0);

  always_ff @(posedge clk) begin
    dl[0] <= ref_alu(alu_a3, alu_b3, alu_ctrl3);
    dl[1] <= dl[0];
    dl[2] <= dl[1];
    dl[3] <= dl[2];
  end
  assign alu_result3 = dl[dly-1];

  // Scoreboard
  typedef struct {
    bit          pass;
    logic [15:0] fc;
    logic [7:0]  ffv;
    logic [3:0]  ffo;
    int          len;
    bit          fc_any;
  } res_t;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
  } stim_t;

  res_t  exp_q[$];
  res_t  exp3_q[$];
  stim_t stim_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string what, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  function automatic res_t mk_res(input bit p, input logic [15:0] fc, input logic [7:0] v,
                                  input logic [3:0] o, input int len, input bit any);
    res_t r;
    r.pass = p; r.fc = fc; r.ffv = v; r.ffo = o; r.len = len; r.fc_any = any;
    return r;
  endfunction

  task automatic push_vec(input logic [31:0] a, input logic [31:0] b);
    logic [3:0] ops [5];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111};
    for (int i = 0; i < 5; i++) begin
      stim_t s;
      s.a = a; s.b = b; s.c = ops[i];
      stim_q.push_back(s);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t r, input logic p, input logic [15:0] fc,
                         input logic [7:0] v, input logic [3:0] o, input int cyc);
    chk({tag, " pass"}, {31'd0, p}, {31'd0, r.pass});
    if (r.fc_any) begin
      chk({tag, " fail_count>0"}, {31'd0, (fc != 16'h0)}, 32'd1);
    end else begin
      chk({tag, " fail_count"}, {16'd0, fc}, {16'd0, r.fc});
      chk({tag, " first_fail_vec"}, {24'd0, v}, {24'd0, r.ffv});
      chk({tag, " first_fail_op"}, {28'd0, o}, {28'd0, r.ffo});
    end
    chk({tag, " run length"}, cyc, r.len);
  endtask

  // Result monitors: pop on the rising edge of done.
  bit dprev = 1'b0, bprev = 1'b0, dprev3 = 1'b0, bprev3 = 1'b0;
  int bcyc = 0, bcyc3 = 0;
  initial begin : mon_done
    forever begin
      @(negedge clk);
      if (busy && !bprev) bcyc = 0;
      if (busy) bcyc++;
      if (done && !dprev) begin
        if (exp_q.size() == 0) chk("dut unexpected done", 32'd1, 32'd0);
        else cmp_res("dut", exp_q.pop_front(), pass, fail_count, ffv, ffo, bcyc);
      end
      if (busy3 && !bprev3) bcyc3 = 0;
      if (busy3) bcyc3++;
      if (done3 && !dprev3) begin
        if (exp3_q.size() == 0) chk("dut3 unexpected done", 32'd1, 32'd0);
        else cmp_res("dut3", exp3_q.pop_front(), pass3, fail_count3, ffv3, ffo3, bcyc3);
      end
      dprev = done; bprev = busy; dprev3 = done3; bprev3 = busy3;
    end
  end

  // Stimulus monitor: every load of a new (a,b,ctrl) while busy is checked in order.
  bit          sprev = 1'b0;
  logic [67:0] prev_tr = '0;
  initial begin : mon_stim
    forever begin
      @(negedge clk);
      if (busy && (!sprev || {alu_a, alu_b, alu_ctrl} != prev_tr) && stim_q.size() > 0) begin
        stim_t s;
        s = stim_q.pop_front();
        chk("stim alu_a", alu_a, s.a);
        chk("stim alu_b", alu_b, s.b);
        chk("stim alu_ctrl", {28'd0, alu_ctrl}, {28'd0, s.c});
      end
      sprev   = busy;
      prev_tr = {alu_a, alu_b, alu_ctrl};
    end
  end

  task automatic pulse(input bit which);
    @(posedge clk); #1;
    if (which) start3 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start3 = 1'b0;
  endtask

  task automatic wait_done(input bit which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      seen = which ? done3 : done;
    end
    if (!seen) chk(which ? "dut3 done timeout" : "dut done timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " pass"}, {31'd0, pass}, 32'd0);
    chk({tag, " fail_count"}, {16'd0, fail_count}, 32'd0);
    chk({tag, " first_fail_vec"}, {24'd0, ffv}, 32'd0);
    chk({tag, " first_fail_op"}, {28'd0, ffo}, 32'd0);
    chk({tag, " alu_a"}, alu_a, 32'd0);
    chk({tag, " alu_b"}, alu_b, 32'd0);
    chk({tag, " alu_ctrl"}, {28'd0, alu_ctrl}, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    reset = 1'b1; start = 1'b0; start3 = 1'b0; add_fault = 1'b0; dly = 2;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // Correct ALU: first two vectors walk all five ops, run passes.
    push_vec(V0A, V0B);
    push_vec(V1A, V1B);
    exp_q.push_back(mk_res(1'b1, 16'd0, 8'd0, 4'd0, LEN1, 1'b0));
    pulse(1'b0);
    wait_done(1'b0, LEN1 + 20);

    // ADD result off by one: every vector fails once, first at vector 0 / ADD.
    add_fault = 1'b1;
    exp_q.push_back(mk_res(1'b0, 16'(NV + NCORN), 8'd0, 4'b0010, LEN1, 1'b0));
    pulse(1'b0);
    wait_done(1'b0, LEN1 + 20);
    add_fault = 1'b0;

    // start reasserted mid-run is ignored.
    exp_q.push_back(mk_res(1'b1, 16'd0, 8'd0, 4'd0, LEN1, 1'b0));
    pulse(1'b0);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, LEN1 + 20);

    // Reset mid-run clears everything; a fresh start replays vector 0.
    push_vec(V0A, V0B);
    pulse(1'b0);
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("abort");
    reset = 1'b0;
    push_vec(V0A, V0B);
    exp_q.push_back(mk_res(1'b1, 16'd0, 8'd0, 4'd0, LEN1, 1'b0));
    pulse(1'b0);
    wait_done(1'b0, LEN1 + 20);

    // SETTLE_CYCLES=3: a 2-cycle ALU settles in time, a 4-cycle one does not.
    dly = 2;
    exp3_q.push_back(mk_res(1'b1, 16'd0, 8'd0, 4'd0, LEN3, 1'b0));
    pulse(1'b1);
    wait_done(1'b1, LEN3 + 20);
    dly = 4;
    exp3_q.push_back(mk_res(1'b0, 16'd0, 8'd0, 4'd0, LEN3, 1'b1));
    pulse(1'b1);
    wait_done(1'b1, LEN3 + 20);

    repeat (2) @(negedge clk);
    chk("dut results drained", exp_q.size(), 32'd0);
    chk("dut3 results drained", exp3_q.size(), 32'd0);
    chk("stimulus drained", stim_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
Built-in self-test initiator for the processor ALU. It drives the ALU's A, B and ALUControl inputs, waits for the result to settle, and checks ALUResult against an internal golden model. It counts mismatches and captures the first failure. It sits beside the ALU in the datapath, with a mux ahead of the ALU inputs selected by busy. It is the in-silicon counterpart of the ALU bench.

Parameters:
NUM_VECTORS, 16, number of random (A,B) pairs; each pair is applied with all 5 ops
SETTLE_CYCLES, 1, cycles to wait after applying a stimulus before sampling alu_result (legal range 1..15)
SEED_A, 32'hAAAA_5555, LFSR seed for A
SEED_B, 32'h5555_AAAA, LFSR seed for B

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  level; sampled in IDLE or DONE only
busy  out  1  high from the cycle after start is accepted until DONE
done  out  1  level; high in DONE until the next accepted start or reset
pass  out  1  valid while done=1; 1 iff fail_count==0
fail_count  out  16  saturating mismatch count
first_fail_vec  out  8  vector index of first mismatch (0 if none)
first_fail_op  out  4  ALUControl of first mismatch (0 if none)
alu_a  out  32  ALU operand A (registered)
alu_b  out  32  ALU operand B (registered)
alu_ctrl  out  4  ALUControl (registered)
alu_result  in  32  ALU result

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all outputs 0; FSM in IDLE; both LFSRs reloaded with their seeds. A seed of 0 is replaced by 32'h1.
- Op table, applied in this order for each vector:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 ADD: A+B, mod 2^32
  - 0110 SUB: A-B, mod 2^32
  - 0111 SLT: signed A<B ? 1 : 0, zero-extended
- Other ALUControl codes are never driven.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE, start=1: on that edge, clear fail_count, first_fail_*, done and pass; reload the LFSRs; load vector 0 / op AND onto alu_*; set busy=1; set the wait counter to SETTLE_CYCLES; go to WAIT.
- WAIT: the counter decrements each cycle. Leave for CHECK on the edge where the counter reaches 1. WAIT therefore lasts exactly SETTLE_CYCLES cycles.
- CHECK, one cycle:
  - Compare alu_result with the expected value, computed from the registered alu_a/alu_b/alu_ctrl.
  - On mismatch, fail_count increments and saturates at 16'hFFFF.
  - If this is the first mismatch, capture first_fail_vec and first_fail_op.
  - On the same edge, load the next stimulus and return to WAIT.
  - After SLT of the last vector, go to DONE instead: busy=0, done=1, pass=(fail_count==0), including this cycle's result.
- The LFSRs advance once per vector, on the CHECK edge that follows SLT.
- LFSR: 32-bit Galois, shift right; when the LSB is 1, XOR the state with 32'h8020_0003.
- Run length: start edge to the done=1 cycle is NUM_VECTORS*5*(SETTLE_CYCLES+1) cycles.
- alu_* hold their last values in DONE and IDLE.
- start while busy is ignored. start held high in DONE restarts the run immediately.
- reset mid-run aborts to IDLE with reset values on the next edge. No partial results are retained.

Optional Feature:
ALU_BIST_CORNER_EN:
- Defined: 4 directed vectors precede the LFSR vectors, with indices 0..3:
  - (0,0)
  - (FFFF_FFFF, 0000_0001)
  - (8000_0000, 7FFF_FFFF)
  - (7FFF_FFFF, FFFF_FFFF)
- The LFSR vectors follow, numbered from index 4. Run length uses NUM_VECTORS+4 vectors.
- The LFSRs do not advance during corner vectors.
- Undefined: LFSR vectors only, starting at index 0.

Test Plan:
1. Correct ALU model, NUM_VECTORS=4, SETTLE_CYCLES=1, macro off; pulse start -> busy for 40 cycles, then done=1, pass=1, fail_count=0; first vector alu_a=AAAA_5555, alu_b=5555_AAAA, and alu_ctrl walks 0,1,2,6,7.
2. ALU model with ADD result XOR 1, NUM_VECTORS=4 -> fail_count=4, pass=0, first_fail_vec=0, first_fail_op=4'b0010.
3. Macro on, correct ALU -> at vector 1 ADD the expected result is 0000_0000 (wrap); at vector 2 SLT the expected result is 1, and SUB gives 0000_0001; pass=1 after (4+4)*5*2=80 cycles.
4. Assert start again at cycle 10 of a run -> ignored; done still arrives at cycle 40 and the counters are unaffected.
5. Assert reset at cycle 15 of a run -> next cycle: all outputs 0, IDLE. A following start reproduces the vector-0 stimulus from case 1.
6. SETTLE_CYCLES=3, ALU result delayed 2 cycles -> pass=1; with the delay at 4 cycles -> fail_count>0.
